// File: rtl/counter_bist_pkg.sv
// Shared types and constants for the counter BIST engine.
package counter_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    DRAIN,
    DONE
  } bist_state_e;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback taps bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

  // Number of cycles the counter is held in reset before a run.
  localparam int unsigned RST_LEN = 2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAP_MASK), cur[15:1]};
  endfunction

endpackage

// File: rtl/counter_bist_checker_lfsr16.sv
// 16-bit Fibonacci LFSR used as the stimulus source; reloadable from a seed.
module lfsr16
  import counter_bist_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;

  // Reset and load both restore the seed; otherwise advance only when stepped.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      q_q <= seed;
    end else if (step) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_bist_checker.sv
// Built-in self-test for a WIDTH-bit up-counter: drives randomized enable/reset,
// tracks a reference model and records mismatches against the counter output.
module counter_bist_checker
  import counter_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned RUN_CYCLES = 50,
  parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dut_count,
  output logic                 dut_enable,
  output logic                 dut_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_got,
  output logic [15:0]          first_err_cycle
);

  localparam logic [15:0]          SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]          RUN_LAST = 16'(RUN_CYCLES - 1);
  localparam logic [1:0]           RST_LAST = 2'(RST_LEN - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  bist_state_e          state_q, state_d;
  logic [1:0]           rst_cnt_q;
  logic [15:0]          run_cnt_q;
  logic [15:0]          cyc_q;
  logic                 busy_q, done_q;
  logic                 dut_enable_q, dut_reset_q;
  logic [WIDTH-1:0]     ref_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [WIDTH-1:0]     fe_exp_q, fe_got_q;
  logic [15:0]          fe_cyc_q;

  logic                 accept;
  logic                 lfsr_step;
  logic                 cmp_active;
  logic                 mismatch;
  logic [15:0]          lfsr_q;
  logic                 unused_lfsr_bits;

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RST;
          accept  = 1'b1;
        end
      end
      RST:     if (rst_cnt_q == RST_LAST) state_d = RUN;
      RUN:     if (run_cnt_q == RUN_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // The LFSR steps while its current value is being registered into the
  // outputs of a RUN cycle, so RUN cycle k sees the seed advanced k times.
  assign lfsr_step = (state_d == RUN);

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .seed  (SEED_EFF),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q[15:3];

  // FSM state, phase counters and registered stimulus/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      run_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dut_enable_q <= 1'b0;
      dut_reset_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= (state_q == RST) ? rst_cnt_q + 2'd1 : '0;
      run_cnt_q    <= (state_q == RUN) ? run_cnt_q + 16'd1 : '0;
      busy_q       <= (state_d == RST) || (state_d == RUN) || (state_d == DRAIN);
      done_q       <= (state_d == DONE);
      dut_reset_q  <= (state_d == RST) || ((state_d == RUN) && lfsr_q[1] && lfsr_q[2]);
      dut_enable_q <= (state_d == RUN) && lfsr_q[0];
    end
  end

  // Reference counter fed by the same registered controls the counter sees.
  always_ff @(posedge clk) begin
    if (reset || dut_reset_q) begin
      ref_q <= '0;
    end else if (dut_enable_q) begin
      ref_q <= ref_q + WIDTH'(1);
    end
  end

  assign cmp_active = (state_q == RUN) || (state_q == DRAIN);
  assign mismatch   = cmp_active && (ref_q != dut_count);

  // Mismatch accounting; a zero error count marks the first failure of a run.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      err_cnt_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
      fe_cyc_q  <= '0;
      cyc_q     <= '0;
    end else if (cmp_active) begin
      cyc_q <= cyc_q + 16'd1;
      if (mismatch) begin
        if (err_cnt_q != ERR_MAX) begin
          err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
        if (err_cnt_q == '0) begin
          fe_exp_q <= ref_q;
          fe_got_q <= dut_count;
          fe_cyc_q <= cyc_q;
        end
      end
    end
  end

  assign dut_enable      = dut_enable_q;
  assign dut_reset       = dut_reset_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q && (err_cnt_q == '0);
  assign err_count       = err_cnt_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_got   = fe_got_q;
  assign first_err_cycle = fe_cyc_q;

endmodule

// File: doc/counter_bist_checker.md
# counter_bist_checker

Synthesizable built-in self-test engine for the team's WIDTH-bit up-counter with reset/enable. It generates pseudo-random enable and reset stimulus, runs a cycle-accurate reference model, compares it against the counter's `count` every cycle, and reports pass/fail plus first-failure details. It sits beside the counter under test on the FPGA, replacing the simulation-only bench when checking on hardware.

## Interface
- `WIDTH`, 4: counter width.
- `RUN_CYCLES`, 50: number of randomized stimulus cycles, 1..65535.
- `LFSR_SEED`, 16'hACE1: LFSR seed. A value of 0 is replaced by 16'h0001.
- `ERR_CNT_W`, 8: width of the mismatch counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `start` in 1: single-cycle pulse that launches a test run.
- `dut_count` in WIDTH: the counter's `count` output.
- `dut_enable` out 1: registered enable to the counter.
- `dut_reset` out 1: registered synchronous reset to the counter.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high in DONE, held until the next accepted start or reset.
- `pass` out 1: `done` AND (`err_count` == 0).
- `err_count` out ERR_CNT_W: mismatch cycles, saturating.
- `first_err_exp` out WIDTH: model value at the first mismatch.
- `first_err_got` out WIDTH: `dut_count` value at the first mismatch.
- `first_err_cycle` out 16: RUN/DRAIN cycle index of the first mismatch, 0-based.

## Operation
- FSM states:
  - IDLE to RST when `start`.
  - RST for 2 cycles, then RUN.
  - RUN for RUN_CYCLES cycles, then DRAIN.
  - DRAIN for 1 cycle, then DONE.
  - DONE to RST when `start`.
- `start` is ignored in RST, RUN and DRAIN.
- Accepting `start` (from IDLE or DONE) in one cycle:
  - reloads the LFSR with the seed;
  - clears `err_count`, first-error fields, `done` and the cycle index.
- Stimulus:
  - RST: `dut_reset`=1, `dut_enable`=0.
  - RUN: `dut_enable`=lfsr[0]; `dut_reset`=lfsr[1]&lfsr[2], roughly 25% of cycles.
  - IDLE, DRAIN and DONE: both outputs 0.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances once per RUN cycle only.
- Reference model: WIDTH-bit register `ref`, updated on every `clk` edge from the same registered `dut_reset`/`dut_enable` values the counter receives.
  - `dut_reset`=1: `ref` becomes 0.
  - Else `dut_enable`=1: `ref` becomes `ref`+1 mod 2^WIDTH, wrapping 2^WIDTH-1 to 0.
  - Otherwise `ref` holds.
- Compare:
  - Active in RUN and DRAIN, every cycle, `ref` against `dut_count`.
  - Mismatch increments `err_count`, saturating at 2^ERR_CNT_W-1.
  - The first mismatch of a run latches `first_err_exp`, `first_err_got` and `first_err_cycle`. Later mismatches leave these fields unchanged.
- Reset mid-run: FSM goes to IDLE, every output returns to its reset value, and the run is abandoned with no result.

## Timing
- Reset values: every output is 0, FSM is IDLE, the LFSR holds the seed.
- `start` sampled at edge E:
  - `busy`=1 and `dut_reset`=1 from E+1.
  - RUN from E+3.
  - DRAIN at E+3+RUN_CYCLES.
  - `done`=1, `busy`=0 from E+4+RUN_CYCLES.
- `err_count` and the first-error fields update one cycle after the mismatching compare cycle. The DRAIN compare is reflected before `done` rises.
- `busy` and `done` are never high together.
- A simultaneous mismatch and saturation keeps `err_count` at its maximum.

## Structure
- Package `counter_bist_pkg` holds:
  - the FSM state enum (IDLE, RST, RUN, DRAIN, DONE);
  - the LFSR tap mask constant;
  - the default seed;
  - the RST length constant (2).
- Sub-module `lfsr16`, with ports `clk`, `reset`, `load`, `seed`, `step` and `q[15:0]`, used for stimulus.
- The reference model, comparator and FSM live in the top level.

## Test plan
- **Correct counter:** correct WIDTH=4 counter, RUN_CYCLES=50, start pulse.
  - `done` rises 54 cycles after the start edge.
  - `pass`=1, `err_count`=0.
- **Stuck-at bit:** counter with `count[0]` stuck at 0.
  - `pass`=0, `err_count`>0.
  - `first_err_got[0]`=0, `first_err_exp[0]`=1.
  - `first_err_cycle` = index of the first RUN cycle where `ref` becomes odd.
- **Enable ignored:** counter that ignores `enable` (always counts).
  - The first error is latched at the first compare after an `enable`=0, `reset`=0 cycle.
  - `first_err_exp` = `first_err_got` - 1 mod 16.
- **Saturation:** ERR_CNT_W=2 with a counter whose output is stuck at 4'hF.
  - `err_count` saturates at 3, `pass`=0.
- **Reset mid-run:** assert `reset` in the 10th RUN cycle.
  - Next cycle: `busy`=0, `done`=0, `err_count`=0, `dut_reset`=0, `dut_enable`=0, FSM IDLE.
- **Start while busy / restart:**
  - A `start` pulse during RUN is ignored, with no change to the completion time.
  - A `start` pulse in DONE clears results and replays the identical `dut_enable`/`dut_reset` sequence, giving the same outcome.
